uart_v2_rx: RTL and testbench
=============================

Name: uart_v2_rx

Overview:
Serial receive stage for the MCU. It sits upstream of the MCU's receive-data and receive-status registers, mirroring the uart_v2_tx transmit path. It oversamples the async line at 4x bit rate, derived from sysclk by a prescaler, and decodes 8N1 frames with majority voting. Received bytes are buffered in a small FIFO that the MCU pops through a read strobe.

Parameters:
CLKS_PER_SAMPLE, 109, sysclk cycles per sample tick (50 MHz / 460800 ≈ 109 for 115200 bps).
FIFO_DEPTH, 4, received-byte buffer depth; must be a power of 2, ≥ 2.

Ports:
sysclk  in  1  system clock; all logic on its rising edge.
sysreset  in  1  synchronous, active-high reset.
rx_line  in  1  async serial input; idles high.
rx_read  in  1  pop strobe, one cycle per byte; ignored when FIFO is empty.
clear_errors  in  1  clears the sticky error flags.
rx_data  out  8  FIFO head byte; valid only while rx_valid=1.
rx_valid  out  1  FIFO is non-empty.
rx_busy  out  1  a frame is in progress (state ≠ IDLE).
framing_error  out  1  sticky: a stop bit was sampled low.
overrun  out  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset (synchronous, sysreset=1):
  - synchronizer flops = 1, state = IDLE, prescaler = 0;
  - FIFO empty, so rx_valid=0 and rx_data=0;
  - rx_busy=0, framing_error=0, overrun=0.
  - Reset mid-frame aborts the frame; no partial byte is kept.
- Input sync: 2-flop synchronizer. All decoding uses the synchronized line (rxs), so latency from rx_line is 2 clocks.
- Prescaler:
  - Held at 0 in IDLE.
  - Otherwise counts 0..CLKS_PER_SAMPLE-1 and wraps.
  - tick = (prescaler == CLKS_PER_SAMPLE-1).
- Sample index k:
  - k=0 is the cycle IDLE sees rxs=0.
  - Sample k is taken at that cycle + k*CLKS_PER_SAMPLE clocks.
  - Bit window b spans samples 4b..4b+3; the bit value is the majority of samples 4b+1, 4b+2, 4b+3.
- States:
  - IDLE: rxs=0 -> START, k=0.
  - START (b=0): after sample 3, majority=1 (glitch) -> IDLE, nothing recorded; else -> DATA.
  - DATA (b=1..8): bits shifted in LSB first; after the sample-3 of b=8 -> STOP.
  - STOP (b=9): at sample 39:
    - majority=1 -> push byte, -> IDLE;
    - majority=0 -> set framing_error, discard byte, -> WAIT_HIGH.
  - WAIT_HIGH: stay until rxs=1, then -> IDLE. A held break line produces exactly one framing error.
- Returning to IDLE at sample 39 leaves ≥1/4 bit before the next start edge.
- FIFO:
  - Push occurs in the cycle after the sample-39 tick; rx_valid rises the following cycle.
  - rx_data is registered FIFO head, first-word-fall-through.
  - Pop when rx_read && rx_valid.
- Boundary cases:
  - Push while full and no pop: byte dropped, overrun set.
  - Push and pop in the same cycle while full: both occur, count unchanged, no overrun.
  - Push and pop in the same cycle while empty: pop is ignored, push occurs.
  - rx_read while empty: no effect; pointers never underflow.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally; full/empty are tracked with a count of width log2(FIFO_DEPTH)+1.
- Sticky flags: clear_errors clears both. If a set and a clear happen in the same cycle, set wins.
- rx_busy = (state ≠ IDLE), registered.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum: IDLE, START, DATA, STOP, WAIT_HIGH;
  - SAMPLES_PER_BIT=4, DATA_BITS=8;
  - majority3 function.
- Sub-module sync_fifo (#WIDTH, DEPTH): push/pop/full/empty/count. It is reusable for a future TX buffer.

Test Plan:
All scenarios use CLKS_PER_SAMPLE=4 (1 bit = 16 clocks).
1. Send 0x55 8N1 -> rx_valid=1 and rx_data=0x55 at 2+39*4+2 clocks after the start edge; framing_error=0; one rx_read -> rx_valid=0.
2. Pulse rx_line low for 4 clocks only -> rx_busy high for ~16 clocks then low; rx_valid=0; no flags set.
3. Send 0xA3 with stop bit 0, then hold the line low 100 clocks, then send 0x0F -> framing_error=1 and no 0xA3 byte; 0x0F received; clear_errors -> framing_error=0.
4. Send 0x01..0x05 back-to-back with no reads -> overrun=1; four pops return 0x01, 0x02, 0x03, 0x04; then rx_valid=0.
5. Fill FIFO with 0x10..0x13; assert rx_read in the exact push cycle of 0x14 -> overrun=0; pops return 0x11, 0x12, 0x13, 0x14.
6. Assert sysreset during data bit 4 of 0xC7, then send 0x3C -> after reset all outputs are 0, rx_busy=0, FIFO empty; 0x3C received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_v2 receive/transmit paths.
// Holds the receiver state encoding, frame geometry and the sample voter.
// No logic of its own; imported by the rx top and future tx blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    localparam int SAMPLES_PER_BIT = 4;
    localparam int DATA_BITS       = 8;

    // Two-out-of-three vote over the samples taken inside one bit window.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with a registered first-word-fall-through head.
// Latency: a push is visible on dout/empty the cycle after it is accepted.
// Backpressure: push is dropped while full unless a pop frees a slot that cycle; pop ignored while empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO can still accept a push when the same cycle frees the head slot.
    assign do_push = push && (!full || do_pop);

    // Storage array; written only on an accepted push, never reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Registered head: tracks the entry at rd_ptr, zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else if (do_pop) begin
            if (count == (AW+1)'(1)) begin
                dout <= do_push ? din : '0;
            end else begin
                dout <= mem[rd_ptr + AW'(1)];
            end
        end else if (empty && do_push) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/uart_v2_rx.sv
// 8N1 UART receiver: 4x oversampling, 3-sample majority vote, byte FIFO toward the MCU.
// Latency: byte appears on rx_valid 2 + 39*CLKS_PER_SAMPLE + 2 clocks after the start edge.
// Backpressure: none toward the line; a byte arriving to a full FIFO is dropped and flags overrun.
module uart_v2_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_SAMPLE = 109,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       sysclk,
    input  logic       sysreset,
    input  logic       rx_line,
    input  logic       rx_read,
    input  logic       clear_errors,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       framing_error,
    output logic       overrun
);

    localparam int PW = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
    localparam int SW = $clog2(SAMPLES_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    rx_state_t state, state_next;

    logic          sync_ff;
    logic          rxs;
    logic [PW-1:0] presc;
    logic          tick;
    logic [SW-1:0] sub;
    logic [1:0]    votes;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          push_req;
    logic          decide;
    logic          maj;
    logic          shift_en;
    logic          stop_ok;
    logic          stop_bad;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          pop_ok;
    logic          ovr_set;

    assign tick   = (presc == PW'(CLKS_PER_SAMPLE - 1));
    // The third sample of a bit window is the current tick; the first two are held in votes.
    assign decide = tick && (sub == SW'(SAMPLES_PER_BIT - 2));
    assign maj    = majority3(votes[0], votes[1], rxs);

    // Two-flop synchronizer on the asynchronous line; idles high.
    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            sync_ff <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            sync_ff <= rx_line;
            rxs     <= sync_ff;
        end
    end

    // FSM state register.
    always_ff @(posedge sysclk) begin
        if (sysreset) state <= IDLE;
        else          state <= state_next;
    end

    // FSM next-state: walk start, data and stop windows on each bit decision.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (!rxs) state_next = START;
            START:     if (decide) state_next = maj ? IDLE : DATA;
            DATA:      if (decide && bit_cnt == 3'(DATA_BITS - 1)) state_next = STOP;
            STOP:      if (decide) state_next = maj ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rxs) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // FSM outputs: data shift strobe and stop-bit verdicts.
    always_comb begin
        shift_en = 1'b0;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        case (state)
            DATA: shift_en = decide;
            STOP: begin
                stop_ok  = decide && maj;
                stop_bad = decide && !maj;
            end
            default: ;
        endcase
    end

    // Sample timing, vote capture, data shift register and the delayed push strobe.
    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            presc    <= '0;
            sub      <= '0;
            votes    <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            push_req <= 1'b0;
            rx_busy  <= 1'b0;
        end else begin
            if (state == IDLE || tick) presc <= '0;
            else                       presc <= presc + PW'(1);

            if (state == IDLE) sub <= '0;
            else if (tick)     sub <= sub + SW'(1);

            if (tick && sub == SW'(0)) votes[0] <= rxs;
            if (tick && sub == SW'(1)) votes[1] <= rxs;

            if (state != DATA) bit_cnt <= '0;
            else if (shift_en) bit_cnt <= bit_cnt + 3'd1;

            if (shift_en) shreg <= {maj, shreg[7:1]};

            push_req <= stop_ok;
            rx_busy  <= (state_next != IDLE);
        end
    end

    assign pop_ok  = rx_read && !fifo_empty;
    assign ovr_set = push_req && fifo_full && !pop_ok;

    // Sticky error flags; a new error in the clearing cycle survives the clear.
    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            if (stop_bad)          framing_error <= 1'b1;
            else if (clear_errors) framing_error <= 1'b0;

            if (ovr_set)           overrun <= 1'b1;
            else if (clear_errors) overrun <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sysclk),
        .rst   (sysreset),
        .push  (push_req),
        .pop   (rx_read),
        .din   (shreg),
        .dout  (rx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign rx_valid = (fifo_count != '0);

endmodule

// File: tb/tb_uart_v2_rx.sv
// Directed plus random bench for uart_v2_rx at CLKS_PER_SAMPLE=4 (16 clocks per bit).
// Expected bytes and flags come from a queue-based model of frames, FIFO depth and sticky errors.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same offset.
module tb_uart_v2_rx;

    localparam int CPS   = 4;
    localparam int DEPTH = 4;
    localparam int BITCLK = 4 * CPS;

    logic       sysclk = 1'b0;
    logic       sysreset;
    logic       rx_line;
    logic       rx_read;
    logic       clear_errors;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       framing_error;
    logic       overrun;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic       exp_fe;
    logic       exp_ovr;

    uart_v2_rx #(
        .CLKS_PER_SAMPLE (CPS),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .sysclk        (sysclk),
        .sysreset      (sysreset),
        .rx_line       (rx_line),
        .rx_read       (rx_read),
        .clear_errors  (clear_errors),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_busy       (rx_busy),
        .framing_error (framing_error),
        .overrun       (overrun)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    // Drives one 8N1 frame; the stop bit is held one clock short so the caller
    // lands exactly in the push cycle (159 clocks after the start edge).
    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_line = bits[i];
            clk_n(i == 9 ? BITCLK - 1 : BITCLK);
        end
    endtask

    // Full frame with model update; a bad stop leaves the line low for a while.
    task automatic run_frame(input logic [7:0] d, input logic stop);
        send_frame(d, stop);
        clk_n(1);
        if (stop) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(d);
            else                      exp_ovr = 1'b1;
        end else begin
            exp_fe = 1'b1;
            clk_n($urandom_range(10, 60));
            rx_line = 1'b1;
            clk_n(8);
        end
    endtask

    task automatic pop_expect(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_empty_valid"}, rx_valid, 0);
            chk({tag, "_empty_data"}, rx_data, 0);
            rx_read = 1'b1; clk_n(1); rx_read = 1'b0;
            chk({tag, "_empty_after_read"}, rx_valid, 0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_valid"}, rx_valid, 1);
            chk({tag, "_data"}, rx_data, e);
            rx_read = 1'b1; clk_n(1); rx_read = 1'b0;
        end
    endtask

    task automatic clear_flags();
        clear_errors = 1'b1; clk_n(1); clear_errors = 1'b0;
        exp_fe = 1'b0; exp_ovr = 1'b0;
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_fe"}, framing_error, exp_fe);
        chk({tag, "_ovr"}, overrun, exp_ovr);
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] c7;
        sysreset = 1'b1; rx_line = 1'b1; rx_read = 1'b0; clear_errors = 1'b0;
        exp_fe = 1'b0; exp_ovr = 1'b0;
        clk_n(3);
        sysreset = 1'b0;
        clk_n(1);

        // Reset state
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_busy", rx_busy, 0);
        chk_flags("rst");
        clk_n(4);

        // Test 1: 0x55 with exact latency
        send_frame(8'h55, 1'b1);
        chk("t1_valid_before_push", rx_valid, 0);
        clk_n(1);
        chk("t1_valid_at_latency", rx_valid, 1);
        chk("t1_data_at_latency", rx_data, 8'h55);
        exp_q.push_back(8'h55);
        chk_flags("t1");
        pop_expect("t1_pop");
        chk("t1_valid_after_pop", rx_valid, 0);

        // Test 2: 4-clock glitch is rejected
        clk_n(8);
        rx_line = 1'b0; clk_n(4);
        chk("t2_busy_during", rx_busy, 1);
        rx_line = 1'b1; clk_n(20);
        chk("t2_busy_after", rx_busy, 0);
        chk("t2_valid", rx_valid, 0);
        chk_flags("t2");

        // Test 3: bad stop bit followed by a break, then a good byte
        send_frame(8'hA3, 1'b0);
        clk_n(1);
        exp_fe = 1'b1;
        chk_flags("t3_after_bad_stop");
        clk_n(100);
        chk("t3_busy_in_break", rx_busy, 1);
        chk("t3_no_byte", rx_valid, 0);
        rx_line = 1'b1; clk_n(8);
        chk("t3_busy_released", rx_busy, 0);
        run_frame(8'h0F, 1'b1);
        chk_flags("t3_single_fe");
        pop_expect("t3_pop");
        clear_flags();
        chk_flags("t3_cleared");

        // Test 4: five back-to-back bytes overrun a four-deep FIFO
        for (int i = 1; i <= 5; i++) run_frame(8'(i), 1'b1);
        chk_flags("t4");
        for (int i = 0; i < 5; i++) pop_expect("t4_pop");
        clear_flags();
        chk_flags("t4_cleared");

        // Test 5: pop in the exact push cycle of a full FIFO
        for (int i = 0; i < 4; i++) run_frame(8'h10 + 8'(i), 1'b1);
        send_frame(8'h14, 1'b1);
        chk("t5_head_before", rx_data, exp_q[0]);
        rx_read = 1'b1; clk_n(1); rx_read = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(8'h14);
        chk_flags("t5");
        for (int i = 0; i < 5; i++) pop_expect("t5_pop");

        // Test 6: reset during data bit 4 of 0xC7
        c7 = 8'hC7;
        rx_line = 1'b0; clk_n(BITCLK);
        for (int i = 0; i < 4; i++) begin
            rx_line = c7[i]; clk_n(BITCLK);
        end
        rx_line = c7[4]; clk_n(8);
        chk("t6_busy_pre_reset", rx_busy, 1);
        sysreset = 1'b1; rx_line = 1'b1; clk_n(2);
        sysreset = 1'b0; clk_n(1);
        exp_q.delete(); exp_fe = 1'b0; exp_ovr = 1'b0;
        chk("t6_valid", rx_valid, 0);
        chk("t6_data", rx_data, 0);
        chk("t6_busy", rx_busy, 0);
        chk_flags("t6");
        clk_n(4);
        run_frame(8'h3C, 1'b1);
        pop_expect("t6_pop");
        pop_expect("t6_pop_empty");

        // Random frames with occasional bad stops, pops and clears
        for (int n = 0; n < 24; n++) begin
            d = 8'($urandom);
            run_frame(d, $urandom_range(0, 4) != 0);
            chk_flags("rnd");
            for (int p = $urandom_range(0, 2); p > 0; p--) pop_expect("rnd_pop");
            if ($urandom_range(0, 3) == 0) begin
                clear_flags();
                chk_flags("rnd_clear");
            end
            clk_n($urandom_range(1, 6));
        end
        for (int i = 0; i < DEPTH + 1; i++) pop_expect("rnd_drain");
        chk("final_busy", rx_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
